// File: rtl/mem_tipos_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_tipos
//  Description : Shared types for the store-side sub-word write path:
//                store size encodings, the store FSM state type and the
//                natural-alignment check for SB/SH/SW requests.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_tipos;

    // Store size encodings as presented on req_size; 2'b11 is illegal.
    localparam logic [1:0] TAM_BYTE    = 2'b00;
    localparam logic [1:0] TAM_MEIA    = 2'b01;
    localparam logic [1:0] TAM_PALAVRA = 2'b10;

    // Store sequencer states.
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LE      = 2'd1,
        ESCREVE = 2'd2,
        FIM     = 2'd3
    } estado_t;

    // True when the access is naturally aligned for its size and the size
    // encoding itself is legal.
    function automatic logic alinhamento_ok(input logic [1:0] offset,
                                            input logic [1:0] tam);
        logic ok;
        case (tam)
            TAM_BYTE:    ok = 1'b1;
            TAM_MEIA:    ok = ~offset[0];
            TAM_PALAVRA: ok = (offset == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : mem_tipos
`default_nettype wire

// File: rtl/insere_parcial.sv
`default_nettype none
// ============================================================================
//  Module      : insere_parcial
//  Description : Combinational lane insertion. Places the low byte or low
//                halfword of 'dado' into the little-endian lane selected by
//                'offset' inside 'palavra'; every other bit of 'palavra' is
//                passed through unchanged. A full-word size returns 'dado'.
//                This is the write-side inverse of the load extender.
//  Ports       : palavra   in  32  existing memory word
//                dado      in  32  store data (low 8/16 bits for byte/half)
//                offset    in  2   byte offset inside the word
//                tam       in  2   size encoding (mem_tipos::TAM_*)
//                resultado out 32  merged word
//  Revision    : 1.0 - initial release
// ============================================================================
module insere_parcial
    import mem_tipos::*;
(
    input  logic [31:0] palavra,
    input  logic [31:0] dado,
    input  logic [1:0]  offset,
    input  logic [1:0]  tam,
    output logic [31:0] resultado
);

    always_comb begin
        resultado = palavra;
        case (tam)
            TAM_BYTE: begin
                case (offset)
                    2'd0:    resultado[7:0]   = dado[7:0];
                    2'd1:    resultado[15:8]  = dado[7:0];
                    2'd2:    resultado[23:16] = dado[7:0];
                    default: resultado[31:24] = dado[7:0];
                endcase
            end
            TAM_MEIA: begin
                // offset[0] is guaranteed zero by the alignment check.
                if (offset[1]) begin
                    resultado[31:16] = dado[15:0];
                end else begin
                    resultado[15:0]  = dado[15:0];
                end
            end
            TAM_PALAVRA: resultado = dado;
            default:     resultado = palavra;
        endcase
    end

endmodule : insere_parcial
`default_nettype wire

// File: rtl/armazena_parcial.sv
`default_nettype none
// ============================================================================
//  Module      : armazena_parcial
//  Description : Store-side sub-word write unit. Turns SB/SH/SW requests into
//                whole-word accesses on a word-only data memory. Byte and
//                halfword stores read the target word, merge the new lane and
//                write it back; word stores write directly. Misaligned or
//                illegal-size requests are rejected with a one-cycle pulse.
//  Ports       : clock, reset (async, active-high)
//                req_valid/req_ready/req_addr/req_data/req_size : request
//                mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata/mem_ack : memory
//                done             : one-cycle pulse, store completed
//                erro_alinhamento : one-cycle pulse, request rejected
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module armazena_parcial
    import mem_tipos::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              erro_alinhamento
);

    estado_t r_estado;
    estado_t w_prox_estado;

    // Captured request fields needed by the read-modify-write merge.
    logic [31:0]       r_dado;
    logic [1:0]        r_offset;
    logic [1:0]        r_tam;

    // Registered outputs.
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [31:0]       r_mem_wdata;
    logic              r_done;
    logic              r_erro;

    // Next values of the registered outputs.
    logic              w_prox_ready;
    logic [ADDR_W-1:0] w_prox_addr;
    logic              w_prox_rd;
    logic              w_prox_wr;
    logic [31:0]       w_prox_wdata;
    logic              w_prox_done;
    logic              w_prox_erro;

    logic              w_aceita;
    logic              w_legal;
    logic              w_captura;
    logic [31:0]       w_mesclada;

    // req_ready is only high while idle, so acceptance implies OCIOSO.
    assign w_aceita  = req_valid && r_req_ready;
    assign w_legal   = alinhamento_ok(req_addr[1:0], req_size);
    assign w_captura = w_aceita && w_legal;

    insere_parcial u_insere (
        .palavra   (mem_rdata),
        .dado      (r_dado),
        .offset    (r_offset),
        .tam       (r_tam),
        .resultado (w_mesclada)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_req_ready <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_erro      <= 1'b0;
            r_dado      <= '0;
            r_offset    <= '0;
            r_tam       <= '0;
        end else begin
            r_estado    <= w_prox_estado;
            r_req_ready <= w_prox_ready;
            r_mem_addr  <= w_prox_addr;
            r_mem_rd    <= w_prox_rd;
            r_mem_wr    <= w_prox_wr;
            r_mem_wdata <= w_prox_wdata;
            r_done      <= w_prox_done;
            r_erro      <= w_prox_erro;
            if (w_captura) begin
                r_dado   <= req_data;
                r_offset <= req_addr[1:0];
                r_tam    <= req_size;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (w_captura) begin
                    w_prox_estado = (req_size == TAM_PALAVRA) ? ESCREVE : LE;
                end
            end
            LE: begin
                if (mem_ack) begin
                    w_prox_estado = ESCREVE;
                end
            end
            ESCREVE: begin
                if (mem_ack) begin
                    w_prox_estado = FIM;
                end
            end
            default: w_prox_estado = OCIOSO;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: strobes follow the state being entered, so each one is
    // high exactly while the FSM sits in the matching state and drops the
    // cycle after mem_ack. Being mutually exclusive states, rd and wr can
    // never overlap.
    // ------------------------------------------------------------------
    always_comb begin
        w_prox_rd    = (w_prox_estado == LE);
        w_prox_wr    = (w_prox_estado == ESCREVE);
        w_prox_done  = (w_prox_estado == FIM);
        // A rejected request stays in OCIOSO but still drops ready for one
        // cycle, so the requester sees the error before it can resubmit.
        w_prox_ready = (w_prox_estado == OCIOSO) && !w_aceita;
        w_prox_erro  = w_aceita && !w_legal;

        w_prox_addr  = r_mem_addr;
        w_prox_wdata = r_mem_wdata;
        if (w_captura) begin
            w_prox_addr = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_size == TAM_PALAVRA) begin
                w_prox_wdata = req_data;
            end
        end
        if ((r_estado == LE) && mem_ack) begin
            w_prox_wdata = w_mesclada;
        end
    end

    assign req_ready        = r_req_ready;
    assign mem_addr         = r_mem_addr;
    assign mem_rd           = r_mem_rd;
    assign mem_wr           = r_mem_wr;
    assign mem_wdata        = r_mem_wdata;
    assign done             = r_done;
    assign erro_alinhamento = r_erro;

endmodule : armazena_parcial
`default_nettype wire

// File: tb/tb_armazena_parcial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_armazena_parcial
//  Description : Self-checking bench for armazena_parcial. A word memory with
//                programmable read/write wait states answers the DUT; a
//                reference word array updated with mask/shift arithmetic
//                predicts memory contents and completion timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_armazena_parcial;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic        erro_alinhamento;

    armazena_parcial #(.ADDR_W(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_size         (req_size),
        .mem_addr         (mem_addr),
        .mem_rd           (mem_rd),
        .mem_wr           (mem_wr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .done             (done),
        .erro_alinhamento (erro_alinhamento)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem_arr [0:63];
    logic [31:0] ref_mem [0:63];
    int          rd_wait = 0;
    int          wr_wait = 0;
    bit          manual  = 1'b0;
    int          wcnt    = 0;
    int          wr_count = 0;
    logic [31:0] wr_last_addr = '0;
    logic [31:0] wr_last_data = '0;
    int          overlap = 0;

    always begin
        @(posedge clock);
        #1;
        if (!manual) begin
            mem_ack = 1'b0;
            if (reset) begin
                wcnt = 0;
            end else if (mem_rd || mem_wr) begin
                if (wcnt >= (mem_rd ? rd_wait : wr_wait)) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    if (mem_rd) begin
                        mem_rdata = mem_arr[mem_addr[7:2]];
                    end else begin
                        mem_arr[mem_addr[7:2]] = mem_wdata;
                        wr_count++;
                        wr_last_addr = mem_addr;
                        wr_last_data = mem_wdata;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    always @(negedge clock) if (mem_rd && mem_wr) overlap++;

    // ---------------- reference model ----------------
    function automatic bit model_legal(input logic [1:0] off, input logic [1:0] s);
        if (s == 2'd3) return 1'b0;
        if (s == 2'd1) return (off % 2) == 0;
        if (s == 2'd2) return off == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                                input logic [1:0] off, input logic [1:0] s);
        int          sh;
        logic [31:0] mask;
        if (s == 2'd2) return d;
        if (s == 2'd0) begin
            sh   = 8 * int'(off);
            mask = 32'hFF << sh;
        end else begin
            sh   = 16 * (int'(off) / 2);
            mask = 32'hFFFF << sh;
        end
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic check_reset_vals();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rd",    32'(mem_rd), 32'd0);
        chk("rst_wr",    32'(mem_wr), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_erro",  32'(erro_alinhamento), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
    endtask

    // ---------------- one request ----------------
    // Called at posedge+2 with the DUT idle. Cycle numbers count from the
    // accept cycle (0). With hold set, the next request is presented with
    // req_valid kept high right after this one is accepted.
    int first_rd, first_wr, done_c, err_c, ready_c, rd_cycles;

    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input int rw, input int ww, input bit hold,
                          input logic [31:0] na, input logic [31:0] nd, input logic [1:0] ns);
        bit          legal;
        int          idx;
        int          wc0;
        logic [31:0] exp_word;
        legal = model_legal(a[1:0], s);
        idx   = int'(a[7:2]);
        wc0   = wr_count;
        rd_wait = rw;
        wr_wait = ww;
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        @(posedge clock); #2;
        if (hold) begin
            req_addr = na; req_data = nd; req_size = ns;
        end else begin
            req_valid = 1'b0;
        end
        first_rd = -1; first_wr = -1; done_c = -1; err_c = -1; ready_c = -1; rd_cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mem_rd) begin
                rd_cycles++;
                if (first_rd < 0) first_rd = c;
            end
            if (mem_wr && first_wr < 0) first_wr = c;
            if (done && done_c < 0) done_c = c;
            if (erro_alinhamento && err_c < 0) err_c = c;
            if (req_ready) begin
                ready_c = c;
                break;
            end
            @(posedge clock); #2;
        end
        if (!legal) begin
            chk("err_cycle",   32'(err_c), 32'd1);
            chk("err_ready",   32'(ready_c), 32'd2);
            chk("err_no_rd",   32'(first_rd), 32'hFFFF_FFFF);
            chk("err_no_wr",   32'(first_wr), 32'hFFFF_FFFF);
            chk("err_no_done", 32'(done_c), 32'hFFFF_FFFF);
            chk("err_wcount",  32'(wr_count - wc0), 32'd0);
        end else begin
            exp_word     = model_merge(ref_mem[idx], d, a[1:0], s);
            ref_mem[idx] = exp_word;
            chk("no_err", 32'(err_c), 32'hFFFF_FFFF);
            if (s == 2'd2) begin
                chk("sw_no_rd", 32'(first_rd), 32'hFFFF_FFFF);
                chk("sw_wr_c",  32'(first_wr), 32'd1);
                chk("sw_done",  32'(done_c), 32'(2 + ww));
                chk("sw_ready", 32'(ready_c), 32'(3 + ww));
            end else begin
                chk("rmw_rd_c",   32'(first_rd), 32'd1);
                chk("rmw_rd_len", 32'(rd_cycles), 32'(rw + 1));
                chk("rmw_wr_c",   32'(first_wr), 32'(2 + rw));
                chk("rmw_done",   32'(done_c), 32'(3 + rw + ww));
                chk("rmw_ready",  32'(ready_c), 32'(4 + rw + ww));
            end
            chk("wcount",  32'(wr_count - wc0), 32'd1);
            chk("wr_addr", wr_last_addr, {a[31:2], 2'b00});
            chk("wr_data", wr_last_data, exp_word);
            chk("mem_word", mem_arr[idx], exp_word);
        end
    endtask

    initial begin
        int saw;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        #12;
        check_reset_vals();
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #2;

        // Directed cases
        mem_arr[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        do_req(32'h11, 32'h0000_00AB, 2'b00, 0, 0, 1'b0, '0, '0, '0);
        chk("sb_word", mem_arr[4], 32'h1122_AB44);
        mem_arr[8] = 32'hFFFF_0000; ref_mem[8] = 32'hFFFF_0000;
        do_req(32'h22, 32'h0000_BEEF, 2'b01, 3, 0, 1'b0, '0, '0, '0);
        chk("sh_word", mem_arr[8], 32'hBEEF_0000);
        do_req(32'h40, 32'hDEAD_BEEF, 2'b10, 0, 0, 1'b0, '0, '0, '0);
        chk("sw_word", mem_arr[16], 32'hDEAD_BEEF);
        do_req(32'h03, 32'h1234_5678, 2'b01, 0, 0, 1'b0, '0, '0, '0);
        do_req(32'h02, 32'h1234_5678, 2'b10, 0, 0, 1'b0, '0, '0, '0);
        do_req(32'h30, 32'h1234_5678, 2'b11, 0, 0, 1'b0, '0, '0, '0);

        // Back-to-back: SB then SW with req_valid held through the busy period
        do_req(32'h05, 32'h0000_005A, 2'b00, 1, 1, 1'b1, 32'h08, 32'hCAFE_F00D, 2'b10);
        chk("b2b_ready_after_done", 32'(ready_c), 32'(done_c + 1));
        do_req(32'h08, 32'hCAFE_F00D, 2'b10, 0, 2, 1'b0, '0, '0, '0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            do_req(32'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, '0, '0, '0);
        end

        // Reset while reading, then a stale ack
        do_req(32'h0, 32'h0, 2'b11, 0, 0, 1'b0, '0, '0, '0);
        rd_wait = 20;
        req_valid = 1'b1; req_addr = 32'h21; req_data = 32'h77; req_size = 2'b00;
        @(posedge clock); #2;
        req_valid = 1'b0;
        @(posedge clock); #2;
        chk("le_rd_high", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(posedge clock); #2;
        manual = 1'b1;
        mem_ack = 1'b0;
        reset = 1'b0;
        @(posedge clock); #2;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clock); #2;
        mem_ack = 1'b0;
        saw = 0;
        repeat (6) begin
            if (mem_rd || mem_wr || done) saw++;
            @(posedge clock); #2;
        end
        chk("stale_ack_ignored", 32'(saw), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        manual = 1'b0;

        chk("rd_wr_overlap", 32'(overlap), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_armazena_parcial
`default_nettype wire
